// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory bus plus IF/ID register bundle   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_start;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  modport master (
    output imem_addr,
    output imem_start,
    input  imem_instr,
    output if_id_pc,
    output if_id_pc4,
    output if_id_instr,
    output if_id_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_start,
    output imem_instr,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_instr,
    input  if_id_valid
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage : PC sequencing, redirect handling and IF/ID register    |
// | Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stall,
  input  wire logic        flush,
  input  wire logic        branch_taken,
  input  wire logic [31:0] branch_target,
  input  wire logic        jump,
  input  wire logic [31:0] jump_target,
  fetch_stage_if.master    bus,
  output logic             halted,
  output logic             misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      fetch_count,
  output logic [31:0]      stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] c_init_last = 4'(INIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_init_cnt;
  logic [3:0]  w_init_cnt_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic        r_misalign;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_load;
  logic        w_bubble;
  logic        w_misalign_set;
  logic        w_stall_cnt_inc;

  assign w_redirect = jump | branch_taken;
  assign w_target   = jump ? jump_target : branch_target;
  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_pc_nxt        = r_pc;
    w_load          = 1'b0;
    w_bubble        = 1'b0;
    w_misalign_set  = 1'b0;
    w_stall_cnt_inc = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_init_cnt_nxt = r_init_cnt + 4'd1;
        if (r_init_cnt == c_init_last) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_redirect) begin
          w_pc_nxt       = {w_target[31:2], 2'b00};
          w_bubble       = 1'b1;
          w_misalign_set = |w_target[1:0];
        end else begin
          w_pc_nxt        = stall ? r_pc : w_pc_plus4;
          w_stall_cnt_inc = stall;
          if (flush) begin
            w_bubble = 1'b1;
          end else if (!stall) begin
            w_load = 1'b1;
            // Only a word that is actually delivered can stop the fetch stream
            if (bus.imem_instr == HALT_WORD) begin
              w_state_nxt = ST_HALTED;
            end
          end
        end
      end

      ST_HALTED: begin
        w_bubble = 1'b1;
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_ifid_instr <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_load) begin
        r_ifid_pc    <= r_pc;
        r_ifid_pc4   <= w_pc_plus4;
        r_ifid_instr <= bus.imem_instr;
        r_ifid_valid <= 1'b1;
      end else if (w_bubble) begin
        r_ifid_instr <= 32'h0;
        r_ifid_valid <= 1'b0;
      end
      if (w_misalign_set) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.imem_start  = (r_state == ST_INIT);
  assign bus.if_id_pc    = r_ifid_pc;
  assign bus.if_id_pc4   = r_ifid_pc4;
  assign bus.if_id_instr = r_ifid_instr;
  assign bus.if_id_valid = r_ifid_valid;
  assign halted          = (r_state == ST_HALTED);
  assign misalign_err    = r_misalign;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (w_load && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_stall_cnt_inc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: directed scenarios then random traffic, each cycle compared
// against a behavioural model of the fetch stage.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
  logic        halted, misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  fetch_stage_if bus();
  logic [31:0] mem [64];
  assign bus.imem_instr = mem[bus.imem_addr[7:2]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .bus(bus),
    .halted(halted), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  int          m_mode = M_INIT;
  int          m_init_left = 2;
  logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_ipc4 = 32'h0, m_iinstr = 32'h0;
  logic        m_ivalid = 1'b0, m_mis = 1'b0;
  longint      m_fc = 0, m_sc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit f, input bit b,
                       input logic [31:0] bt, input bit j, input logic [31:0] jt);
    logic [31:0] word, tgt;
    if (r) begin
      m_mode = M_INIT; m_init_left = 2; m_pc = RST_PC;
      m_ipc = 0; m_ipc4 = 0; m_iinstr = 0; m_ivalid = 0; m_mis = 0;
      m_fc = 0; m_sc = 0;
    end else if (m_mode == M_INIT) begin
      m_init_left--;
      if (m_init_left == 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      word = mem[(m_pc / 4) % 64];
      if (j || b) begin
        tgt = j ? jt : bt;
        if (tgt % 4 != 0) m_mis = 1;
        m_ivalid = 0; m_iinstr = 0;
        m_pc = tgt - (tgt % 4);
      end else begin
        if (s && m_sc < 64'hFFFF_FFFF) m_sc++;
        if (f) begin
          m_ivalid = 0; m_iinstr = 0;
        end else if (!s) begin
          m_ipc = m_pc; m_ipc4 = m_pc + 4; m_iinstr = word; m_ivalid = 1;
          if (m_fc < 64'hFFFF_FFFF) m_fc++;
          if (word == HALT) m_mode = M_HALT;
        end
        if (!s) m_pc = m_pc + 4;
      end
    end else begin
      m_ivalid = 0; m_iinstr = 0;
    end
  endtask

  task automatic check_all();
    chk("imem_addr",    bus.imem_addr,   m_pc);
    chk("imem_start",   {31'h0, bus.imem_start}, {31'h0, m_mode == M_INIT});
    chk("if_id_pc",     bus.if_id_pc,    m_ipc);
    chk("if_id_pc4",    bus.if_id_pc4,   m_ipc4);
    chk("if_id_instr",  bus.if_id_instr, m_iinstr);
    chk("if_id_valid",  {31'h0, bus.if_id_valid}, {31'h0, m_ivalid});
    chk("halted",       {31'h0, halted}, {31'h0, m_mode == M_HALT});
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_mis});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count",  fetch_count, m_fc[31:0]);
    chk("stall_count",  stall_count, m_sc[31:0]);
`endif
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit b,
                      input logic [31:0] bt, input bit j, input logic [31:0] jt);
    rst = r; stall = s; flush = f; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    model(r, s, f, b, bt, j, jt);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h11;
    mem[1]  = 32'h22;
    mem[2]  = 32'h33;
    mem[3]  = HALT;
    mem[32] = 32'hA5A5_0080;
    @(negedge clk);

    // Reset and INIT, with junk on the control inputs that INIT must ignore
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    chk("rst_start", {31'h0, bus.imem_start}, 32'h1);
    step(0, 1, 1, 1, 32'h44, 1, 32'h88);
    chk("init_hold_addr", bus.imem_addr, 32'h0);
    step(0, 0, 1, 0, 32'h0, 1, 32'h88);
    chk("init_done", {31'h0, bus.imem_start}, 32'h0);

    // Sequential fetch
    idle();
    chk("seq_instr0", bus.if_id_instr, 32'h11);
    idle();
    chk("seq_instr1", bus.if_id_instr, 32'h22);
    chk("seq_pc1", bus.if_id_pc, 32'h4);

    // Stall at address 8
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 32'h0, 0, 32'h0);
      chk("stall_addr", bus.imem_addr, 32'h8);
      chk("stall_pc", bus.if_id_pc, 32'h4);
    end
    idle();
    chk("resume_instr", bus.if_id_instr, 32'h33);
    chk("resume_pc", bus.if_id_pc, 32'h8);

    // Halt word squashed by flush must not halt
    step(0, 0, 1, 0, 32'h0, 0, 32'h0);
    chk("flush_nohalt", {31'h0, halted}, 32'h0);

    // Jump beats branch beats stall
    step(0, 1, 0, 1, 32'h40, 1, 32'h80);
    chk("prio_addr", bus.imem_addr, 32'h80);
    chk("prio_valid", {31'h0, bus.if_id_valid}, 32'h0);
    idle();
    chk("prio_fetch_pc", bus.if_id_pc, 32'h80);

    // Misaligned jump target
    step(0, 0, 0, 0, 32'h0, 1, 32'h42);
    chk("mis_addr", bus.imem_addr, 32'h40);
    chk("mis_flag", {31'h0, misalign_err}, 32'h1);

    // Halt at 0xC
    step(0, 0, 0, 0, 32'h0, 1, 32'hC);
    idle();
    chk("halt_instr", bus.if_id_instr, HALT);
    chk("halt_valid", {31'h0, bus.if_id_valid}, 32'h1);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    step(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 1, 32'h20, 0, 32'h0);
    idle();
    chk("halted_addr", bus.imem_addr, 32'h10);
    chk("halted_valid", {31'h0, bus.if_id_valid}, 32'h0);
    chk("mis_sticky", {31'h0, misalign_err}, 32'h1);

    // Reset out of HALTED
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_mis", {31'h0, misalign_err}, 32'h0);

    // Random traffic
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    for (int n = 0; n < 1500; n++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0) ||
          ((m_mode == M_HALT) && ($urandom_range(0, 7) == 0));
      step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 255),
           $urandom_range(0, 11) == 0, $urandom_range(0, 255));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter INIT_CYCLES, default 2: number of cycles imem_start is held high after reset, range 1..15.
REQ-003 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that halts fetch.
REQ-004 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-006 SHALL have port stall input 1: hold PC and IF/ID register.
REQ-007 SHALL have port flush input 1: squash IF/ID contents.
REQ-008 SHALL have port branch_taken input 1: redirect PC to branch_target.
REQ-009 SHALL have port branch_target input 32: branch destination.
REQ-010 SHALL have port jump input 1: redirect PC to jump_target.
REQ-011 SHALL have port jump_target input 32: jump destination.
REQ-012 SHALL have port imem_addr output 32: byte address to instruction memory; equals PC.
REQ-013 SHALL have port imem_start output 1: drives instruction memory startin.
REQ-014 SHALL have port imem_instr input 32: word returned combinationally by instruction memory for imem_addr.
REQ-015 SHALL have ports if_id_pc output 32, if_id_pc4 output 32, if_id_instr output 32, if_id_valid output 1: IF/ID register contents.
REQ-016 SHALL have port halted output 1: high while FSM is HALTED.
REQ-017 SHALL have port misalign_err output 1: sticky flag for redirect target with bits [1:0] nonzero.

Function
REQ-018 SHALL implement FSM states INIT, RUN, HALTED.
REQ-019 INIT SHALL last exactly INIT_CYCLES cycles with imem_start=1, PC held, if_id_valid=0, then go to RUN; all inputs except rst ignored in INIT.
REQ-020 In RUN, next PC SHALL be: jump ? {jump_target[31:2],2'b00} : branch_taken ? {branch_target[31:2],2'b00} : stall ? PC : PC+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-021 Redirect (jump or branch_taken) SHALL override stall; jump SHALL override branch_taken.
REQ-022 In RUN, IF/ID SHALL update as: flush or redirect -> valid=0, instr=32'h0, pc/pc4 unchanged; else stall -> hold all; else load pc=PC, pc4=PC+4, instr=imem_instr, valid=1.
REQ-023 Fetch-to-IF/ID latency SHALL be one cycle: word at imem_addr in cycle N appears on if_id_instr in cycle N+1.
REQ-024 RUN SHALL go to HALTED when a load per REQ-022 captures imem_instr==HALT_WORD; the halt word itself SHALL be delivered with valid=1.
REQ-025 A halt word coincident with stall, flush or redirect SHALL NOT cause HALTED.
REQ-026 In HALTED, PC SHALL freeze, IF/ID SHALL load bubbles (valid=0, instr=0) every cycle regardless of stall, halted=1; exit only via rst.
REQ-027 misalign_err SHALL set in the cycle after any accepted redirect whose selected target has [1:0]!=0, and clear only on rst.

Reset
REQ-028 On rst high at a clock edge: PC=RESET_PC, FSM=INIT with counter restarted, if_id_pc=0, if_id_pc4=0, if_id_instr=0, if_id_valid=0, halted=0, misalign_err=0, imem_start=1 from next cycle.
REQ-029 rst asserted mid-operation in any state SHALL have the identical effect and priority over all other inputs.

Configuration
REQ-030 With FETCH_PERF_CNT_EN defined, SHALL add outputs fetch_count (32) counting IF/ID valid loads and stall_count (32) counting RUN cycles with stall=1 and no redirect; both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-031 Without FETCH_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset, INIT_CYCLES=2, memory words 0x11,0x22,0x33 at 0,4,8 -> imem_start high 2 cycles; then if_id_instr 0x11,0x22,0x33 with if_id_pc 0,4,8 on consecutive cycles.
REQ-033 stall high 3 cycles while imem_addr=8 -> imem_addr stays 8, IF/ID holds pc=4 for 3 cycles, then resumes pc=8.
REQ-034 branch_taken=1, branch_target=0x40, jump=1, jump_target=0x80, stall=1 same cycle -> next imem_addr=0x80, if_id_valid=0, next fetch pc=0x80.
REQ-035 jump_target=0x42 -> imem_addr=0x40, misalign_err=1 and stays 1 until rst.
REQ-036 HALT_WORD at address 0xC -> IF/ID delivers 0xFFFF_FFFF valid once, halted=1, imem_addr frozen at 0x10, valid=0 thereafter; same word with flush=1 -> no halt.
REQ-037 rst pulsed in HALTED at PC=0x10 -> PC=RESET_PC, halted=0, INIT re-entered; with FETCH_PERF_CNT_EN counters read 0.
